// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 sizes, FSM states,
// fault codes and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    FLT_NONE     = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_TIMEOUT  = 2'b10,
    FLT_ILLEGAL  = 2'b11
  } lsu_fault_t;

  // Illegal encodings take priority over misalignment.
  function automatic lsu_fault_t access_check(input logic rd, input logic wr,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    lsu_fault_t r;
    r = FLT_NONE;
    if (rd && wr)
      r = FLT_ILLEGAL;
    else if (rd && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      r = FLT_ILLEGAL;
    else if (wr && !(f3 inside {F3_B, F3_H, F3_W}))
      r = FLT_ILLEGAL;
    else if ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00))
      r = FLT_MISALIGN;
    return r;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic: store byte replication and strobes, and
// load byte/halfword extraction with sign or zero extension.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_value
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (st_funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << st_off;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << st_off;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_value = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_value = {24'h000000, ld_byte};
      F3_H:    ld_value = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_value = {16'h0000, ld_half};
      default: ld_value = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per EX-stage
// load/store, with pipeline stall, extended load data and fault reporting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  fault
);

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state, state_next;
  lsu_fault_t  chk, fault_q;
  logic        op_present;
  logic [9:0]  cnt;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic [31:0] al_wdata, al_ld_value;
  logic [3:0]  al_wstrb;

  assign op_present = ex_valid & (mem_read | mem_write);
  assign chk        = access_check(mem_read, mem_write, funct3, addr[1:0]);
  assign fault      = fault_q;

  lsu_data_align u_align (
    .st_funct3  (funct3),
    .st_off     (addr[1:0]),
    .store_data (store_data),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .ld_funct3  (lat_funct3),
    .ld_off     (lat_off),
    .rdata      (mem_rdata),
    .ld_value   (al_ld_value)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (op_present) state_next = (chk == FLT_NONE) ? ST_BUS : ST_DONE;
      ST_BUS:  if (mem_ack || cnt == CNT_LAST) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    done  = (state == ST_DONE);
    stall = !reset && op_present && (state != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      load_data  <= '0;
      fault_q    <= FLT_NONE;
      cnt        <= '0;
      lat_funct3 <= '0;
      lat_off    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_present) begin
            if (chk == FLT_NONE) begin
              mem_req    <= 1'b1;
              mem_we     <= mem_write;
              mem_addr   <= {addr[31:2], 2'b00};
              mem_wdata  <= al_wdata;
              mem_wstrb  <= mem_write ? al_wstrb : 4'b0000;
              lat_funct3 <= funct3;
              lat_off    <= addr[1:0];
              cnt        <= '0;
              fault_q    <= FLT_NONE;
            end else begin
              fault_q    <= chk;
              load_data  <= '0;
            end
          end
        end
        ST_BUS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            fault_q <= FLT_NONE;
            if (!mem_we) load_data <= al_ld_value;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            fault_q   <= FLT_TIMEOUT;
            load_data <= '0;
          end else begin
            cnt <= cnt + 10'd1;
          end
        end
        ST_DONE: fault_q <= FLT_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand
// sequences for timeout/late-ack/reset, and randomized ops against a model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack, stall, done;
  logic [31:0] load_data;
  logic [1:0]  fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .fault      (fault)
  );

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a, sd, rdata;
    int          ack_at;     // BUS cycle index (1-based) carrying mem_ack; 0 = none
    logic [1:0]  fault;
    int          done_c, req_n;
    logic [31:0] maddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata, ld;
  } vec_t;

  typedef struct {
    int          done_c, req_n, stall_bad, unstable;
    logic [31:0] maddr, wdata, ld;
    logic        we;
    logic [3:0]  strb;
    logic [1:0]  fault;
  } obs_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3,
                              input logic [31:0] a, sd, rdata, input int ack_at,
                              input logic [1:0] flt, input int done_c, req_n,
                              input logic [31:0] maddr, input logic we,
                              input logic [3:0] strb, input logic [31:0] wdata, ld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.sd = sd; v.rdata = rdata;
    v.ack_at = ack_at; v.fault = flt; v.done_c = done_c; v.req_n = req_n;
    v.maddr = maddr; v.we = we; v.strb = strb; v.wdata = wdata; v.ld = ld;
    return v;
  endfunction

  // Reference model built from the access rules with plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned bytes, off, mask, val;
    logic legal_ld, legal_st;
    r = v;
    bytes    = 1 << v.f3[1:0];
    off      = v.a % 4;
    legal_ld = (v.f3 == 0 || v.f3 == 1 || v.f3 == 2 || v.f3 == 4 || v.f3 == 5);
    legal_st = (v.f3 < 3);
    r.maddr = 0; r.we = 0; r.strb = 0; r.wdata = 0; r.ld = 0;
    if ((v.rd && v.wr) || (v.rd && !legal_ld) || (v.wr && !legal_st)) begin
      r.fault = 3; r.done_c = 1; r.req_n = 0;
    end else if (v.a % bytes != 0) begin
      r.fault = 1; r.done_c = 1; r.req_n = 0;
    end else begin
      r.maddr = v.a - off;
      r.we    = v.wr;
      if (v.wr) begin
        r.strb = 4'(((1 << bytes) - 1) << off);
        if (bytes == 1)      r.wdata = (v.sd % 256) * 32'h0101_0101;
        else if (bytes == 2) r.wdata = (v.sd % 65536) * 32'h0001_0001;
        else                 r.wdata = v.sd;
      end
      if (v.ack_at >= 1 && v.ack_at <= TO) begin
        r.fault = 0; r.done_c = v.ack_at + 1; r.req_n = v.ack_at;
        if (bytes == 4) r.ld = v.rdata;
        else begin
          mask = (bytes == 1) ? 255 : 65535;
          val  = (v.rdata >> (8 * off)) & mask;
          if (v.f3 < 4 && val > mask / 2) val = val - (mask + 1);
          r.ld = val;
        end
      end else begin
        r.fault = 2; r.done_c = TO + 1; r.req_n = TO; r.ld = 0;
      end
    end
    return r;
  endfunction

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic run_op(input vec_t v, output obs_t o);
    o.done_c = -1; o.req_n = 0; o.stall_bad = 0; o.unstable = 0;
    o.maddr = 0; o.wdata = 0; o.ld = 0; o.we = 0; o.strb = 0; o.fault = 0;
    ex_valid = 1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
    addr = v.a; store_data = v.sd; mem_rdata = v.rdata;
    for (int c = 0; c < 16; c++) begin
      mem_ack = (v.ack_at != 0 && c == v.ack_at);
      @(negedge clk);
      if (mem_req) begin
        if (o.req_n == 0) begin
          o.maddr = mem_addr; o.we = mem_we; o.strb = mem_wstrb; o.wdata = mem_wdata;
        end else if (mem_addr !== o.maddr || mem_we !== o.we ||
                     mem_wstrb !== o.strb || mem_wdata !== o.wdata) begin
          o.unstable++;
        end
        o.req_n++;
      end
      if (done) begin
        o.done_c = c; o.fault = fault; o.ld = load_data;
        if (stall !== 1'b0) o.stall_bad++;
      end else if (stall !== 1'b1) begin
        o.stall_bad++;
      end
      @(posedge clk); #1;
      if (o.done_c >= 0) break;
    end
    ex_valid = 0; mem_read = 0; mem_write = 0; mem_ack = 0;
  endtask

  task automatic compare(input string tag, input vec_t e, input obs_t o);
    check({tag, " done_cycle"}, o.done_c, e.done_c);
    check({tag, " fault"}, {30'd0, o.fault}, {30'd0, e.fault});
    check({tag, " req_cycles"}, o.req_n, e.req_n);
    check({tag, " stall_pattern_errors"}, o.stall_bad, 0);
    if (e.req_n > 0) begin
      check({tag, " mem_addr"}, o.maddr, e.maddr);
      check({tag, " mem_we"}, {31'd0, o.we}, {31'd0, e.we});
      check({tag, " mem_wstrb"}, {28'd0, o.strb}, {28'd0, e.strb});
      check({tag, " bus_unstable"}, o.unstable, 0);
      if (e.we) check({tag, " mem_wdata"}, o.wdata, e.wdata);
    end
    if (e.rd && !e.wr && (e.fault == 0 || e.fault == 2))
      check({tag, " load_data"}, o.ld, e.ld);
  endtask

  vec_t tbl[14];
  vec_t v, e;
  obs_t o;
  int   pulses;

  initial begin
    tbl[0]  = mk(1, 0, 3'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 1, 2'd0, 2, 1, 32'h1004, 0, 4'h0, 32'h0, 32'hDEAD_BEEF);
    tbl[1]  = mk(0, 1, 3'd0, 32'h0000_2003, 32'h1234_56A5, 32'h0, 1, 2'd0, 2, 1, 32'h2000, 1, 4'h8, 32'hA5A5_A5A5, 32'h0);
    tbl[2]  = mk(1, 0, 3'd0, 32'h0000_3001, 32'h0, 32'h0000_8000, 2, 2'd0, 3, 2, 32'h3000, 0, 4'h0, 32'h0, 32'hFFFF_FF80);
    tbl[3]  = mk(1, 0, 3'd4, 32'h0000_3001, 32'h0, 32'h0000_8000, 1, 2'd0, 2, 1, 32'h3000, 0, 4'h0, 32'h0, 32'h0000_0080);
    tbl[4]  = mk(1, 0, 3'd1, 32'h0000_3002, 32'h0, 32'h8001_0000, 3, 2'd0, 4, 3, 32'h3000, 0, 4'h0, 32'h0, 32'hFFFF_8001);
    tbl[5]  = mk(1, 0, 3'd5, 32'h0000_3002, 32'h0, 32'h8001_0000, 4, 2'd0, 5, 4, 32'h3000, 0, 4'h0, 32'h0, 32'h0000_8001);
    tbl[6]  = mk(1, 0, 3'd2, 32'h0000_0006, 32'h0, 32'h0, 1, 2'd1, 1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    tbl[7]  = mk(1, 0, 3'd2, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 5, 2'd2, 5, 4, 32'h0100, 0, 4'h0, 32'h0, 32'h0);
    tbl[8]  = mk(0, 1, 3'd1, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 1, 2'd0, 2, 1, 32'h0010, 1, 4'hC, 32'hBEEF_BEEF, 32'h0);
    tbl[9]  = mk(0, 1, 3'd3, 32'h0000_0020, 32'h0, 32'h0, 1, 2'd3, 1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    tbl[10] = mk(1, 1, 3'd2, 32'h0000_0020, 32'h0, 32'h0, 1, 2'd3, 1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    tbl[11] = mk(1, 0, 3'd6, 32'h0000_0020, 32'h0, 32'h0, 1, 2'd3, 1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    tbl[12] = mk(0, 1, 3'd1, 32'h0000_0013, 32'h0, 32'h0, 1, 2'd1, 1, 0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    tbl[13] = mk(0, 1, 3'd2, 32'h0000_0024, 32'h89AB_CDEF, 32'h0, 2, 2'd0, 3, 2, 32'h0024, 1, 4'hF, 32'h89AB_CDEF, 32'h0);

    reset = 1; ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    addr = 0; store_data = 0; mem_rdata = 0; mem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    ex_valid = 1; mem_read = 1;
    @(negedge clk);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset fault", {30'd0, fault}, 32'd0);
    check("reset load_data", load_data, 32'd0);
    check("reset mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    @(posedge clk); #1;
    reset = 0; ex_valid = 0; mem_read = 0;

    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i], o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // Timeout with ack arriving in DONE and again in the following IDLE cycle.
    v = mk(1, 0, 3'd2, 32'h0000_0200, 32'h0, 32'h1111_2222, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    e = model(v);
    run_op(v, o);
    compare("late_ack", e, o);
    mem_ack = 1;
    @(negedge clk);
    check("late_ack idle mem_req", {31'd0, mem_req}, 32'd0);
    check("late_ack idle done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    check("late_ack after done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Reset during the second BUS cycle.
    ex_valid = 1; mem_read = 1; funct3 = 3'd2; addr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    @(negedge clk);
    check("midbus mem_req before reset edge", {31'd0, mem_req}, 32'd1);
    check("midbus stall forced low", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 0; ex_valid = 0; mem_read = 0;
    @(negedge clk);
    check("midbus mem_req after reset", {31'd0, mem_req}, 32'd0);
    check("midbus stall after reset", {31'd0, stall}, 32'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || mem_req) pulses++;
    end
    check("midbus no done or retry", pulses, 0);
    @(posedge clk); #1;
    v = mk(0, 1, 3'd2, 32'h0000_0010, 32'h0BAD_F00D, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    e = model(v);
    run_op(v, o);
    compare("sw_after_reset", e, o);

    for (int i = 0; i < 60; i++) begin
      int unsigned k;
      k = $urandom_range(0, 9);
      v.rd = (k <= 4) || (k == 9);
      v.wr = (k >= 5);
      v.f3 = 3'($urandom_range(0, 7));
      v.a = $urandom;
      if ($urandom_range(0, 1) == 1) v.a[1:0] = 2'b00;
      v.sd = $urandom;
      v.rdata = $urandom;
      v.ack_at = $urandom_range(0, 6);
      e = model(v);
      run_op(v, o);
      compare($sformatf("rnd%0d", i), e, o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
